gcd_operand_sequencer: RTL and testbench

- Upstream feeder for the GCD top-level (clk, start, data_in[15:0], done).
- Accepts one operand pair through a valid/ready handshake.
- Serialises the pair onto the GCD's shared data bus (A first, then B), pulses start, waits for done, then reports completion and accepts the next pair.
- Rejects zero operands, which would make the subtractive GCD loop forever.

---
 rtl/gcd_operand_sequencer_pkg.sv | 31 +++
 rtl/gcd_operand_sequencer_if.sv | 33 +++
 rtl/gcd_operand_sequencer_hold_cnt.sv | 39 +++
 rtl/gcd_operand_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_gcd_operand_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_operand_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared types and constants for the GCD operand sequencer.
//   GCD_W       default operand / data bus width of the GCD datapath
//   HOLD_CNT_W  width of the LOAD hold counter
//   seq_cnt_w() width of the shared sequencer counter; it widens only when the
//               RUN timeout (GCD_SEQ_TIMEOUT_EN) needs more than HOLD_CNT_W bits
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_W      = 16;
    localparam int HOLD_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } gcd_seq_state_e;

    function automatic int seq_cnt_w(input int timeout_cycles, input bit timeout_en);
        int tw;
        tw = $clog2(timeout_cycles + 1);
        if (timeout_en && (tw > HOLD_CNT_W)) begin
            return tw;
        end
        return HOLD_CNT_W;
    endfunction

endpackage

// File: rtl/gcd_operand_sequencer_if.sv
// -----------------------------------------------------------------------------
// gcd_operand_sequencer_if
// Operand-pair valid/ready channel into the GCD operand sequencer.
//   in_valid  producer has a pair on op_a/op_b
//   in_ready  sequencer can take the pair this cycle
//   op_a      first operand (driven onto the GCD bus first)
//   op_b      second operand
// Modports: master = pair producer, slave = sequencer.
// -----------------------------------------------------------------------------
interface gcd_operand_sequencer_if
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        output in_ready
    );
endinterface

// File: rtl/gcd_operand_sequencer_hold_cnt.sv
// -----------------------------------------------------------------------------
// gcd_seq_hold_cnt
// Loadable down-counter used for the LOAD_A/LOAD_B hold time and, when the
// timeout option is built in, the RUN timeout. Counting stops at zero (no wrap).
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement by one if not already zero
//   o_zero     counter is at zero (terminal count)
// -----------------------------------------------------------------------------
module gcd_seq_hold_cnt
    import gcd_pkg::*;
#(
    parameter int CW = HOLD_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gcd_operand_sequencer.sv
// -----------------------------------------------------------------------------
// gcd_operand_sequencer
// Feeds one operand pair at a time to the subtractive GCD: A then B on the
// shared data bus, a start pulse with A, then waits for the GCD done level.
// Pairs containing a zero are rejected (the GCD loop would never terminate).
//
// Optional build macro: GCD_SEQ_TIMEOUT_EN
//   defined   -> RUN aborts after TIMEOUT_CYCLES cycles without done
//   undefined -> RUN waits for done indefinitely, o_err_timeout tied 0
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   up             operand-pair channel (slave side of the valid/ready link)
//   o_gcd_start    start pulse to the GCD (first LOAD_A cycle)
//   o_gcd_data     GCD data_in bus
//   i_gcd_done     GCD done level
//   o_busy         a job is in flight (state != IDLE)
//   o_pair_done    one-cycle pulse after done is seen in RUN
//   o_err_zero     one-cycle pulse after a zero-containing pair is rejected
//   o_err_timeout  one-cycle pulse after a RUN timeout
//
// Parameters: W (bus width), HOLD_CYCLES (1..15 cycles per operand),
//             TIMEOUT_CYCLES (RUN limit, only with GCD_SEQ_TIMEOUT_EN)
//
// state  | meaning
// IDLE   | ready for a pair unless the GCD still shows done
// LOAD_A | A on the bus for HOLD_CYCLES cycles, start on the first
// LOAD_B | B on the bus for HOLD_CYCLES cycles
// RUN    | B held, waiting for done (or timeout)
// DRAIN  | waiting for done to drop before taking the next pair
// -----------------------------------------------------------------------------
module gcd_operand_sequencer
    import gcd_pkg::*;
#(
    parameter int W              = GCD_W,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    gcd_operand_sequencer_if.slave         up,
    output logic                           o_gcd_start,
    output logic [W-1:0]                   o_gcd_data,
    input  logic                           i_gcd_done,
    output logic                           o_busy,
    output logic                           o_pair_done,
    output logic                           o_err_zero,
    output logic                           o_err_timeout
);

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam bit C_TO_EN = 1'b1;
`else
    localparam bit C_TO_EN = 1'b0;
`endif

    localparam int              CNT_W       = seq_cnt_w(TIMEOUT_CYCLES, C_TO_EN);
    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
`ifdef GCD_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    gcd_seq_state_e   r_state;
    gcd_seq_state_e   w_next;

    logic [W-1:0]     r_op_b;
    logic [W-1:0]     r_gcd_data;
    logic             r_gcd_start;
    logic             r_pair_done;
    logic             r_err_zero;

    logic             w_hs;
    logic             w_zero_op;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_set_pair_done;
    logic             w_set_err_zero;
`ifdef GCD_SEQ_TIMEOUT_EN
    logic             w_set_timeout;
    logic             r_err_timeout;
`endif

    // rst_n term keeps in_ready low while reset is asserted.
    assign up.in_ready = rst_n && (r_state == IDLE) && !i_gcd_done;
    assign w_hs        = up.in_valid && up.in_ready;
    assign w_zero_op   = (up.op_a == '0) || (up.op_b == '0);

    gcd_seq_hold_cnt #(
        .CW (CNT_W)
    ) u_hold_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_cnt_load      = 1'b0;
        w_cnt_load_val  = C_HOLD_LOAD;
        w_cnt_dec       = 1'b0;
        w_set_pair_done = 1'b0;
        w_set_err_zero  = 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
        w_set_timeout   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (w_zero_op) begin
                        w_set_err_zero = 1'b1;
                    end else begin
                        w_next     = LOAD_A;
                        w_cnt_load = 1'b1;
                    end
                end
            end
            LOAD_A: begin
                if (w_cnt_zero) begin
                    w_next     = LOAD_B;
                    w_cnt_load = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            LOAD_B: begin
                if (w_cnt_zero) begin
                    w_next = RUN;
`ifdef GCD_SEQ_TIMEOUT_EN
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = C_TO_LOAD;
`endif
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            RUN: begin
                // done takes priority over a timeout reached in the same cycle
                if (i_gcd_done) begin
                    w_set_pair_done = 1'b1;
                    w_next          = DRAIN;
                end
`ifdef GCD_SEQ_TIMEOUT_EN
                else if (w_cnt_zero) begin
                    w_set_timeout = 1'b1;
                    w_next        = DRAIN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (!i_gcd_done) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // A is not kept separately: the data register itself holds it through LOAD_A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_b      <= '0;
            r_gcd_data  <= '0;
            r_gcd_start <= 1'b0;
            r_pair_done <= 1'b0;
            r_err_zero  <= 1'b0;
        end else begin
            r_gcd_start <= 1'b0;
            r_pair_done <= w_set_pair_done;
            r_err_zero  <= w_set_err_zero;
            if (w_hs) begin
                r_op_b <= up.op_b;
            end
            if ((r_state == IDLE) && (w_next == LOAD_A)) begin
                r_gcd_data  <= up.op_a;
                r_gcd_start <= 1'b1;
            end else if ((r_state == LOAD_A) && (w_next == LOAD_B)) begin
                r_gcd_data <= r_op_b;
            end else if (w_next == IDLE) begin
                r_gcd_data <= '0;
            end
        end
    end

`ifdef GCD_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_set_timeout;
        end
    end
    assign o_err_timeout = r_err_timeout;
`else
    assign o_err_timeout = 1'b0;
`endif

    assign o_gcd_start = r_gcd_start;
    assign o_gcd_data  = r_gcd_data;
    assign o_pair_done = r_pair_done;
    assign o_err_zero  = r_err_zero;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gcd_operand_sequencer
// Two sequencer instances (HOLD_CYCLES = 1 and 3) driven by directed and
// random operand pairs. The expected output timeline of each job is derived
// from the job's parameters (hold time, done delay/length, timeout limit);
// the GCD itself is a stub driving gcd_done from the bench.
// -----------------------------------------------------------------------------
module tb_gcd_operand_sequencer;

    localparam int TB_TO = 20;
`ifdef GCD_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic        tb_valid [2];
    logic [15:0] tb_a     [2];
    logic [15:0] tb_b     [2];
    logic        tb_done  [2];

    logic        ob_ready [2];
    logic        ob_start [2];
    logic [15:0] ob_data  [2];
    logic        ob_busy  [2];
    logic        ob_pd    [2];
    logic        ob_ez    [2];
    logic        ob_et    [2];

    int          hold_of  [2];

    int          n_checks;
    int          n_errors;

    gcd_operand_sequencer_if #(.W(16)) u_if0 ();
    gcd_operand_sequencer_if #(.W(16)) u_if1 ();

    assign u_if0.in_valid = tb_valid[0];
    assign u_if0.op_a     = tb_a[0];
    assign u_if0.op_b     = tb_b[0];
    assign ob_ready[0]    = u_if0.in_ready;
    assign u_if1.in_valid = tb_valid[1];
    assign u_if1.op_a     = tb_a[1];
    assign u_if1.op_b     = tb_b[1];
    assign ob_ready[1]    = u_if1.in_ready;

    gcd_operand_sequencer #(
        .W              (16),
        .HOLD_CYCLES    (1),
        .TIMEOUT_CYCLES (TB_TO)
    ) u_dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .up            (u_if0),
        .o_gcd_start   (ob_start[0]),
        .o_gcd_data    (ob_data[0]),
        .i_gcd_done    (tb_done[0]),
        .o_busy        (ob_busy[0]),
        .o_pair_done   (ob_pd[0]),
        .o_err_zero    (ob_ez[0]),
        .o_err_timeout (ob_et[0])
    );

    gcd_operand_sequencer #(
        .W              (16),
        .HOLD_CYCLES    (3),
        .TIMEOUT_CYCLES (TB_TO)
    ) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .up            (u_if1),
        .o_gcd_start   (ob_start[1]),
        .o_gcd_data    (ob_data[1]),
        .i_gcd_done    (tb_done[1]),
        .o_busy        (ob_busy[1]),
        .o_pair_done   (ob_pd[1]),
        .o_err_zero    (ob_ez[1]),
        .o_err_timeout (ob_et[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, act, exp);
        end
    endtask

    task automatic check_outs(input int d, input string tag, input logic e_ready, input logic e_start,
                              input logic e_busy, input logic e_pd, input logic e_ez, input logic e_et);
        chk({tag, ".in_ready"},    d, 32'(ob_ready[d]), 32'(e_ready));
        chk({tag, ".gcd_start"},   d, 32'(ob_start[d]), 32'(e_start));
        chk({tag, ".busy"},        d, 32'(ob_busy[d]),  32'(e_busy));
        chk({tag, ".pair_done"},   d, 32'(ob_pd[d]),    32'(e_pd));
        chk({tag, ".err_zero"},    d, 32'(ob_ez[d]),    32'(e_ez));
        chk({tag, ".err_timeout"}, d, 32'(ob_et[d]),    32'(e_et));
    endtask

    // One job on DUT d. dly = RUN cycles before done rises (negative = never),
    // dlen = cycles done stays high, spur = a done glitch during LOAD_A.
    // Entered and left at a negedge with all checks for that cycle pending.
    task automatic run_job(input int d, input logic [15:0] a, input logic [15:0] b,
                           input int dly, input int dlen, input bit spur, input string tag);
        int          h;
        int          kd;
        int          kdrain;
        int          kidle;
        int          wait_n;
        bit          zero;
        bit          tmo;
        logic [15:0] cap_a;
        logic [15:0] cap_b;
        string       t;

        h      = hold_of[d];
        zero   = (a == 16'd0) || (b == 16'd0);
        tmo    = TO_EN && ((dly < 0) || (dly >= TB_TO));
        cap_a  = '0;
        cap_b  = '0;
        wait_n = 0;
        while ((ob_ready[d] !== 1'b1) && (wait_n < 60)) begin
            @(negedge clk);
            wait_n++;
        end
        chk({tag, ".ready_wait"}, d, 32'(ob_ready[d]), 32'd1);
        tb_valid[d] = 1'b1;
        tb_a[d]     = a;
        tb_b[d]     = b;
        @(negedge clk);
        tb_valid[d] = 1'b0;
        tb_a[d]     = 16'($urandom);
        tb_b[d]     = 16'($urandom);

        if (zero) begin
            check_outs(d, {tag, "@1"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check_outs(d, {tag, "@2"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end

        kd = 2 * h + 1 + dly;
        if (tmo) begin
            kdrain = 2 * h + 1 + TB_TO;
            kidle  = kdrain + 1;
        end else begin
            kdrain = kd + 1;
            kidle  = kd + dlen + 1;
        end

        for (int k = 1; k <= kidle; k++) begin
            if (k > 1) @(negedge clk);
            t = $sformatf("%s@%0d", tag, k);
            check_outs(d, t, k >= kidle, k == 1, k < kidle,
                       !tmo && (k == kdrain), 1'b0, tmo && (k == kdrain));
            if (k < kdrain) begin
                chk({t, ".gcd_data"}, d, 32'(ob_data[d]), (k <= h) ? 32'(a) : 32'(b));
            end
            if (k == 1)     cap_a = ob_data[d];
            if (k == h + 1) cap_b = ob_data[d];
            if (spur && (k == 1)) tb_done[d] = 1'b1;
            if (spur && (k == 2)) tb_done[d] = 1'b0;
            if (!tmo && (k == kd))        tb_done[d] = 1'b1;
            if (!tmo && (k == kd + dlen)) tb_done[d] = 1'b0;
        end
        chk({tag, ".gcd_result"}, d, 32'(gcd_ref(int'(cap_a), int'(cap_b))),
            32'(gcd_ref(int'(a), int'(b))));
    endtask

    // done still high while idle: in_ready must stay low and in_valid is ignored
    task automatic idle_done_block(input int d);
        tb_done[d]  = 1'b1;
        tb_valid[d] = 1'b1;
        tb_a[d]     = 16'd9;
        tb_b[d]     = 16'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_outs(d, $sformatf("idle_done@%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tb_done[d]  = 1'b0;
        tb_valid[d] = 1'b0;
        @(negedge clk);
        check_outs(d, "idle_done_clear", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          rd;

        n_checks   = 0;
        n_errors   = 0;
        hold_of[0] = 1;
        hold_of[1] = 3;
        rst_n      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tb_valid[i] = 1'b0;
            tb_a[i]     = '0;
            tb_b[i]     = '0;
            tb_done[i]  = 1'b0;
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_outs(i, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("reset.gcd_data", i, 32'(ob_data[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_outs(i, "post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        run_job(0, 16'd143, 16'd78, 3, 2, 1'b0, "basic");
        run_job(0, 16'd48,  16'd18, 2, 3, 1'b0, "b2b_1");
        run_job(0, 16'd7,   16'd5,  0, 1, 1'b0, "b2b_2");
        run_job(0, 16'd0,   16'd25, 2, 1, 1'b0, "zero_a");
        run_job(0, 16'd25,  16'd15, 1, 1, 1'b0, "after_zero");
        run_job(1, 16'd100, 16'd75, 2, 2, 1'b0, "hold3");
        run_job(1, 16'd33,  16'd0,  2, 2, 1'b0, "zero_b");
        run_job(0, 16'd60,  16'd36, 4, 2, 1'b1, "spurious");
        run_job(1, 16'd91,  16'd35, 1, 8, 1'b1, "long_done");
        run_job(0, 16'd30,  16'd20, 25, 1, 1'b0, "long_run");
        idle_done_block(0);
        idle_done_block(1);

`ifdef GCD_SEQ_TIMEOUT_EN
        run_job(0, 16'd9,  16'd6,  -1,        1, 1'b0, "timeout_h1");
        run_job(1, 16'd12, 16'd8,  -1,        1, 1'b0, "timeout_h3");
        run_job(0, 16'd21, 16'd14, TB_TO - 1, 2, 1'b0, "done_eq_to");
        run_job(1, 16'd27, 16'd18, TB_TO - 1, 1, 1'b0, "done_eq_to_h3");
        run_job(0, 16'd22, 16'd11, TB_TO - 2, 1, 1'b0, "done_before_to");
`endif

        // reset while in LOAD_B: outputs must clear without waiting for a clock
        run_job(0, 16'd1, 16'd1, 0, 1, 1'b0, "pre_rst");
        tb_valid[0] = 1'b1;
        tb_a[0]     = 16'd500;
        tb_b[0]     = 16'd300;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid.load_b_data", 0, 32'(ob_data[0]), 32'd300);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_outs(i, "rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst_mid.gcd_data", i, 32'(ob_data[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_outs(i, "rst_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        for (int n = 0; n < 16; n++) begin
            rd = int'($urandom_range(0, 1));
            ra = 16'($urandom_range(1, 65535));
            rb = 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 5) == 0) ra = 16'd0;
            if ($urandom_range(0, 5) == 0) rb = 16'd0;
            run_job(rd, ra, rb, int'($urandom_range(0, 6)), int'($urandom_range(1, 4)),
                    1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
